sdram_stream_checker: RTL

Synthesizable, parametrised successor of the bench-side 16-bit ramp checker: sniffs the accepted write beats on the DMA→SDRAM Avalon write port and verifies that the lanes carry a continuous wrapping counter. It counts beats and mismatching lanes, captures the first error, and re-synchronises on error so one glitch is not reported as an endless run of errors. It sits in the bus-clock domain beside `simple_dma`, fed by a tap of `SDRAM_WRITEDATA/WRITE/WAITREQUEST`. Results are exposed as status for the Linux register file.

---
 rtl/stream_chk_pkg.sv | 33 +++
 rtl/sdram_stream_checker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/stream_chk_pkg.sv
// stream_chk_pkg: shared types and helpers for the SDRAM write-stream ramp checker.
// Latency: n/a (pure functions and types).
// Backpressure: n/a.
package stream_chk_pkg;

    // Widest supported lane. Helpers operate at this width and callers truncate.
    localparam int MAX_LANE_W = 32;
    localparam int MAX_PAIR_W = 2 * MAX_LANE_W;

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } sync_state_e;

    // Wrapping counter successor. Callers truncate the result to the lane width,
    // which makes the all-ones value roll over to 0 (modulo arithmetic).
    function automatic logic [MAX_LANE_W-1:0] cnt_next(
        input logic [MAX_LANE_W-1:0] x,
        input logic [MAX_LANE_W-1:0] max
    );
        return (x == max) ? '0 : x + 1'b1;
    endfunction

    // Swap the two lane_w halves of one zero-extended 2*lane_w word.
    // Bits above 2*lane_w in the result are junk and are dropped by the caller.
    function automatic logic [MAX_PAIR_W-1:0] swap_halves(
        input logic [MAX_PAIR_W-1:0] data,
        input int unsigned           lane_w
    );
        return (data >> lane_w) | (data << lane_w);
    endfunction

endpackage

// File: rtl/sdram_stream_checker.sv
// sdram_stream_checker: sniffs accepted SDRAM write beats and checks the lanes carry a wrapping ramp.
// Latency: status reflects a beat 2 edges after the edge that accepted it; 1 beat/cycle.
// Backpressure: none, passive tap; WAITREQUEST only qualifies which beats count.
module sdram_stream_checker
    import stream_chk_pkg::*;
#(
    parameter int  DATA_W      = 128,
    parameter int  LANE_W      = 16,
    parameter int  SWAP_HALVES = 1,
    parameter int  ERR_W       = 16,
    localparam int LANES       = DATA_W / LANE_W,
    localparam int LANE_IDX_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  CLK,
    input  logic                  SRST,
    input  logic                  ENABLE,
    input  logic                  CLEAR,
    input  logic [LANE_W-1:0]     CNT_MAX,
    input  logic [DATA_W-1:0]     SDRAM_WRITEDATA,
    input  logic                  SDRAM_WRITE,
    input  logic                  SDRAM_WAITREQUEST,
    output logic [31:0]           BEAT_CNT,
    output logic [ERR_W-1:0]      ERR_CNT,
    output logic                  ERR_FLAG,
    output logic [LANE_W-1:0]     FIRST_EXP,
    output logic [LANE_W-1:0]     FIRST_GOT,
    output logic [31:0]           FIRST_BEAT,
    output logic [LANE_IDX_W-1:0] FIRST_LANE
);

    localparam int PAIR_W = 2 * LANE_W;
    localparam int MIS_W  = $clog2(LANES + 1);

    // Bus tap: raw beat is captured first so the bus nets only see a flop load.
    logic                  accept;
    logic                  tap_vld_q;
    logic [DATA_W-1:0]     tap_dat_q;

    // Stage 0: lane-ordered (swapped) beat.
    logic [DATA_W-1:0]     swp_dat;
    logic                  s0_vld_q;
    logic [DATA_W-1:0]     s0_dat_q;

    // Stage 1 state and status.
    sync_state_e           state_q;
    logic [LANE_W-1:0]     last_q;
    logic [31:0]           beat_cnt_q;
    logic [ERR_W-1:0]      err_cnt_q;
    logic                  err_flag_q;
    logic [LANE_W-1:0]     first_exp_q;
    logic [LANE_W-1:0]     first_got_q;
    logic [31:0]           first_beat_q;
    logic [LANE_IDX_W-1:0] first_lane_q;

    // Stage 1 compare results.
    logic [LANE_W-1:0]     lane_exp [LANES];
    logic [LANES-1:0]      lane_mis;
    logic [MIS_W-1:0]      mis_cnt;
    logic [LANE_IDX_W-1:0] fst_idx;
    logic [LANE_W-1:0]     fst_exp;
    logic [LANE_W-1:0]     fst_got;
    logic [ERR_W:0]        err_sum;
    logic [ERR_W-1:0]      err_cnt_d;
    logic [31:0]           beat_cnt_d;

    assign accept = SDRAM_WRITE & ~SDRAM_WAITREQUEST & ENABLE;

    // DMA word order: each 2*LANE_W word arrives with its halves exchanged.
    // An unpaired top lane (odd lane count) passes straight through.
    if (SWAP_HALVES != 0) begin : g_swap
        for (genvar k = 0; k < LANES / 2; k++) begin : g_pair
            assign swp_dat[PAIR_W*k +: PAIR_W] =
                PAIR_W'(swap_halves(MAX_PAIR_W'(tap_dat_q[PAIR_W*k +: PAIR_W]), LANE_W));
        end
        if (LANES % 2 != 0) begin : g_odd
            assign swp_dat[DATA_W-1 -: LANE_W] = tap_dat_q[DATA_W-1 -: LANE_W];
        end
    end else begin : g_noswap
        assign swp_dat = tap_dat_q;
    end

    // Lane chain. Whether a lane matched or not, the reference handed on is the
    // received value (on a match they are equal), so each lane simply expects the
    // successor of the lane checked before it. The top lane continues from the
    // bottom lane of the previous beat, or seeds the chain when unsynchronised.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [LANE_W-1:0] prev_ref;
        logic [LANE_W-1:0] got;

        assign got = s0_dat_q[j*LANE_W +: LANE_W];
        assign lane_exp[j] = LANE_W'(cnt_next(MAX_LANE_W'(prev_ref), MAX_LANE_W'(CNT_MAX)));

        if (j == LANES - 1) begin : g_head
            assign prev_ref    = last_q;
            assign lane_mis[j] = (state_q == SYNC) && (got != lane_exp[j]);
        end else begin : g_body
            assign prev_ref    = s0_dat_q[(j+1)*LANE_W +: LANE_W];
            assign lane_mis[j] = (got != lane_exp[j]);
        end
    end

    // Mismatch popcount and first mismatch in check order (highest lane first,
    // so the last hit of an ascending scan wins).
    always_comb begin
        mis_cnt = '0;
        fst_idx = '0;
        fst_exp = '0;
        fst_got = '0;
        for (int j = 0; j < LANES; j++) begin
            if (lane_mis[j]) begin
                mis_cnt = mis_cnt + 1'b1;
                fst_idx = LANE_IDX_W'(j);
                fst_exp = lane_exp[j];
                fst_got = s0_dat_q[j*LANE_W +: LANE_W];
            end
        end
    end

    // Saturating error accumulation and wrapping beat count.
    always_comb begin
        err_sum    = {1'b0, err_cnt_q} + (ERR_W+1)'(mis_cnt);
        err_cnt_d  = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
        beat_cnt_d = beat_cnt_q + 32'd1;
    end

    // Beat payloads; only meaningful under their valid bits, so left unreset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            tap_dat_q <= SDRAM_WRITEDATA;
        end
        if (tap_vld_q) begin
            s0_dat_q <= swp_dat;
        end
    end

    // Pipeline valids, sync FSM and status; reset/clear drop in-flight beats.
    always_ff @(posedge CLK) begin
        if (SRST || CLEAR) begin
            tap_vld_q    <= 1'b0;
            s0_vld_q     <= 1'b0;
            state_q      <= UNSYNC;
            last_q       <= '0;
            beat_cnt_q   <= '0;
            err_cnt_q    <= '0;
            err_flag_q   <= 1'b0;
            first_exp_q  <= '0;
            first_got_q  <= '0;
            first_beat_q <= '0;
            first_lane_q <= '0;
        end else begin
            tap_vld_q <= accept;
            s0_vld_q  <= tap_vld_q;
            if (s0_vld_q) begin
                state_q    <= SYNC;
                last_q     <= s0_dat_q[LANE_W-1:0];
                beat_cnt_q <= beat_cnt_d;
                err_cnt_q  <= err_cnt_d;
                if (!err_flag_q && (|lane_mis)) begin
                    err_flag_q   <= 1'b1;
                    first_exp_q  <= fst_exp;
                    first_got_q  <= fst_got;
                    first_beat_q <= beat_cnt_q;
                    first_lane_q <= fst_idx;
                end
            end
        end
    end

    assign BEAT_CNT   = beat_cnt_q;
    assign ERR_CNT    = err_cnt_q;
    assign ERR_FLAG   = err_flag_q;
    assign FIRST_EXP  = first_exp_q;
    assign FIRST_GOT  = first_got_q;
    assign FIRST_BEAT = first_beat_q;
    assign FIRST_LANE = first_lane_q;

endmodule
